// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory arbiter: default bus widths,
// the largest supported master count and the lock state encoding.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_REQ    = 4;
    localparam int IDX_W      = 2;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

    // Successor of a master index, wrapping at the configured master count.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur, input int n);
        if (int'(cur) >= n - 1) begin
            return '0;
        end else begin
            return cur + IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after start_i,
// wrapping modulo N, wins; result is given one-hot and encoded.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [MAX_REQ-1:0] req_pad_s;
    logic [MAX_REQ-1:0] gnt_pad_s;
    logic [IDX_W:0]     sum_s;
    logic [IDX_W-1:0]   pos_s;

    // Walk the masters from start_i and stop at the first live request.
    always_comb begin
        req_pad_s = MAX_REQ'(req_i);
        gnt_pad_s = '0;
        idx_o     = '0;
        any_o     = 1'b0;
        sum_s     = '0;
        pos_s     = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, start_i} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(N)) begin
                sum_s = sum_s - (IDX_W+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            pos_s = sum_s[IDX_W-1:0];
            if (!any_o && req_pad_s[pos_s]) begin
                gnt_pad_s[pos_s] = 1'b1;
                idx_o            = pos_s;
                any_o            = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
        gnt_o = gnt_pad_s[N-1:0];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ masters,
// with a per-transfer lock for read-modify-write and a 1-deep read tag pipeline.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    lock_state_e        state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [IDX_W-1:0]   mem_id_q;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [MAX_REQ-1:0] owner_pad_s;
    logic [NUM_REQ-1:0] req_masked_s, pick_gnt_s;
    logic [IDX_W-1:0]   start_s, pick_idx_s;
    logic               pick_any_s, accept_s;
    logic               sel_we_s, sel_lock_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;

    // While locked only the owner may compete; the search starts after last_owner.
    always_comb begin
        owner_pad_s = {{(MAX_REQ-1){1'b0}}, 1'b1} << owner_q;
        case (state_q)
            LK_LOCKED: req_masked_s = req & owner_pad_s[NUM_REQ-1:0];
            default:   req_masked_s = req;
        endcase
        start_s = next_idx(last_q, NUM_REQ);
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_masked_s),
        .start_i (start_s),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Grant gating and selection of the winning master's command fields.
    always_comb begin
        if (rst) begin
            gnt      = pick_gnt_s;
            accept_s = pick_any_s;
        end else begin
            gnt      = '0;
            accept_s = 1'b0;
        end
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_s == IDX_W'(i)) begin
                sel_we_s    = we[i];
                sel_lock_s  = lock[i];
                sel_addr_s  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[i*DATA_W +: DATA_W];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    // Lock FSM and round-robin pointer advance on every accepted transfer.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept_s) begin
            last_d = pick_idx_s;
            if (sel_lock_s) begin
                state_d = LK_LOCKED;
                owner_d = pick_idx_s;
            end else begin
                state_d = LK_UNLOCKED;
            end
        end else begin
            last_d = last_q;
        end
    end

    // A read issued last cycle returns to the master recorded in the tag stage.
    always_comb begin
        rvalid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mem_en_q && !mem_we_q && (mem_id_q == IDX_W'(i))) begin
                rvalid_d[i] = 1'b1;
            end else begin
                rvalid_d[i] = 1'b0;
            end
        end
        if (|rvalid_q) begin
            rdata = mem_rdata;
        end else begin
            rdata = '0;
        end
    end

    // State, memory command and tag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LK_UNLOCKED;
            owner_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_id_q    <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            mem_en_q <= accept_s;
            mem_we_q <= accept_s & sel_we_s;
            rvalid_q <= rvalid_d;
            if (accept_s) begin
                mem_addr_q  <= sel_addr_s;
                mem_wdata_q <= sel_wdata_s;
                mem_id_q    <= pick_idx_s;
            end else begin
                mem_addr_q  <= mem_addr_q;
                mem_wdata_q <= mem_wdata_q;
                mem_id_q    <= mem_id_q;
            end
        end
    end

    assign rvalid    = rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected memory commands and
// read returns into queues; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk, rst;
    logic [N-1:0]    req, we, lock, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_en, mem_we;

    logic [AW-1:0] a_m [N];
    logic [AW-1:0] nxt_a [N];
    logic [DW-1:0] d_m [N];
    logic [DW-1:0] nxt_d [N];

    int checks = 0;
    int errors = 0;

    typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} mexp_t;
    typedef struct {int id; logic [DW-1:0] d;} rexp_t;
    mexp_t mq[$];
    rexp_t rq[$];
    mexp_t m_pop;
    rexp_t r_pop;

    logic [DW-1:0] mem_model [int];

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = a_m[i];
            wdata[i*DW +: DW] = d_m[i];
        end
    end

    // Synchronous single-port memory; unwritten words read as 0xA000 | address.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_model[int'(mem_addr)] = mem_wdata;
            end else if (mem_model.exists(int'(mem_addr))) begin
                mem_rdata <= mem_model[int'(mem_addr)];
            end else begin
                mem_rdata <= 16'hA000 | mem_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mq.size() == 0) begin
                chk("mem_en_unexpected", 32'd1, 32'd0);
            end else begin
                m_pop = mq.pop_front();
                chk("mem_we", 32'(mem_we), 32'(m_pop.w));
                chk("mem_addr", 32'(mem_addr), 32'(m_pop.a));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_pop.d));
            end
        end
        if (rvalid != '0) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid), 32'd0);
            end else begin
                r_pop = rq.pop_front();
                chk("rvalid_id", 32'(rvalid), 32'd1 << r_pop.id);
                chk("rdata", 32'(rdata), 32'(r_pop.d));
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                        input logic [N-1:0] eg, input logic [DW-1:0] ed, input bit exp_rd = 1'b1);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            a_m[i] = nxt_a[i];
            d_m[i] = nxt_d[i];
        end
        req  = r;
        we   = w;
        lock = l;
        #1;
        chk("gnt", 32'(gnt), 32'(eg));
        for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
                mq.push_back('{w[i], a_m[i], d_m[i]});
                if (!w[i] && exp_rd) rq.push_back('{i, ed});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req = '0; we = '0; lock = '0;
        for (int i = 0; i < N; i++) begin
            a_m[i] = '0; d_m[i] = '0;
            nxt_a[i] = 16'h0010 + 16'(i);
            nxt_d[i] = 16'h0D00 + 16'(i);
        end
        repeat (2) @(negedge clk);
        req = 3'b111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b1;

        // Round-robin rotation from reset
        step(3'b111, 3'b000, 3'b000, 3'b001, 16'hA010);
        step(3'b111, 3'b000, 3'b000, 3'b010, 16'hA011);
        step(3'b111, 3'b000, 3'b000, 3'b100, 16'hA012);
        step(3'b111, 3'b000, 3'b000, 3'b001, 16'hA010);

        // Write by master 1 then read-back by master 2
        nxt_a[1] = 16'h0040; nxt_d[1] = 16'hBEEF;
        step(3'b010, 3'b010, 3'b000, 3'b010, 16'h0000);
        nxt_a[2] = 16'h0040;
        step(3'b100, 3'b000, 3'b000, 3'b100, 16'hBEEF);

        // Locked read by master 2 blocks others until its unlocked write
        nxt_a[2] = 16'h0012;
        step(3'b100, 3'b000, 3'b100, 3'b100, 16'hA012);
        repeat (3) step(3'b011, 3'b000, 3'b000, 3'b000, 16'h0000);
        nxt_a[2] = 16'h0020; nxt_d[2] = 16'h1234;
        step(3'b111, 3'b100, 3'b000, 3'b100, 16'h0000);
        step(3'b011, 3'b000, 3'b000, 3'b001, 16'hA010);

        // Master 0 loses to 2, then withdraws; master 1 wins
        step(3'b101, 3'b000, 3'b000, 3'b100, 16'h1234);
        step(3'b010, 3'b000, 3'b000, 3'b010, 16'hBEEF);
        repeat (3) step(3'b000, 3'b000, 3'b000, 3'b000, 16'h0000);

        // Reset while a read is in flight drops its return
        step(3'b100, 3'b000, 3'b000, 3'b100, 16'h0000, 1'b0);
        @(negedge clk);
        req = '0;
        #2 rst = 1'b0;
        #1 req = 3'b111;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_rvalid2", 32'(rvalid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_mem_en2", 32'(mem_en), 32'd0);
        req = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        step(3'b111, 3'b000, 3'b000, 3'b001, 16'hA010);

        // Single master streaming reads
        for (int i = 0; i < 8; i++) begin
            nxt_a[0] = 16'(i);
            step(3'b001, 3'b000, 3'b000, 3'b001, 16'hA000 | 16'(i));
        end
        repeat (4) step(3'b000, 3'b000, 3'b000, 3'b000, 16'h0000);

        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
